// File: rtl/m_cond_unit.sv
// ---------------------------------------------------------------------------
// m_cond_unit - condition-evaluation stage between decode and issue.
//
// Extracts the 4-bit condition field of each instruction, evaluates it
// against one of NUM_FLAG_SETS banked NZCV registers, and hands a registered
// {kind, cond, pass, sets_flags, flag_sel} bundle to issue over valid/ready.
// Conditional instructions are interlocked against older, still-in-flight
// flag writers on the same set using per-set pending counters.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              synchronous pipeline flush
//   in_valid/in_ready  decode-side handshake
//   in_kind            instruction kind, passed through unchanged
//   in_instruction     raw instruction; condition at [COND_LSB+3:COND_LSB]
//   in_sets_flags      instruction writes flags at execute
//   in_flag_sel        flag set read/written by the instruction
//   out_valid/out_ready issue-side handshake
//   out_kind, out_cond, out_pass, out_sets_flags, out_flag_sel
//                      registered results
//   wb_valid, wb_flag_sel, wb_flags  flag writeback, wb_flags = {N,Z,C,V}
//
// Build option:
//   COND_UNIT_WB_BYPASS_EN  when defined, a writeback retiring the last
//                           pending writer of a set is forwarded into
//                           evaluation so the dependent instruction is
//                           accepted in the writeback cycle.
// ---------------------------------------------------------------------------

package m_cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } e_cond;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_MEM    = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_SYS    = 2'd3
    } e_kind;

endpackage

module m_cond_unit
    import m_cond_unit_pkg::*;
#(
    parameter int INSTR_WIDTH   = 32,
    parameter int COND_LSB      = 28,
    parameter int NUM_FLAG_SETS = 1,
    parameter int MAX_PENDING   = 4,
    parameter int FSEL_W        = (NUM_FLAG_SETS > 1) ? $clog2(NUM_FLAG_SETS) : 1,
    parameter int PEND_W        = $clog2(MAX_PENDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  e_kind                  in_kind,
    input  logic [INSTR_WIDTH-1:0] in_instruction,
    input  logic                   in_sets_flags,
    input  logic [FSEL_W-1:0]      in_flag_sel,

    output logic                   out_valid,
    input  logic                   out_ready,
    output e_kind                  out_kind,
    output e_cond                  out_cond,
    output logic                   out_pass,
    output logic                   out_sets_flags,
    output logic [FSEL_W-1:0]      out_flag_sel,

    input  logic                   wb_valid,
    input  logic [FSEL_W-1:0]      wb_flag_sel,
    input  logic [3:0]             wb_flags
);

    // Storage is sized to the full select space so any select value indexes
    // a real entry; entries at or above NUM_FLAG_SETS are never written.
    localparam int NSETS = 1 << FSEL_W;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [3:0]        flags_q [NSETS];
    logic [PEND_W-1:0] pend_q  [NSETS];

    logic              sel_in_range;
    logic              wb_in_range;
    logic              wb_hit;
    logic [PEND_W-1:0] pend_cur;
    e_cond             cond_p0;
    logic              dep_p0;
    logic              set_ready;
    logic [3:0]        eval_flags;
    logic              pass_p0;
    logic              stall;
    logic              accept;
    logic [NSETS-1:0]  pend_inc;
    logic [NSETS-1:0]  wb_sel_vec;

    // Only the condition field of the instruction is consumed here.
    logic              unused_instr;
    assign unused_instr = ^in_instruction;

    function automatic logic sel_ok(input logic [FSEL_W-1:0] sel);
        return int'(sel) < NUM_FLAG_SETS;
    endfunction

    function automatic logic cond_eval(input e_cond cond, input logic [3:0] f);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = !z;
            COND_CS: r = c;
            COND_CC: r = !c;
            COND_MI: r = n;
            COND_PL: r = !n;
            COND_VS: r = v;
            COND_VC: r = !v;
            COND_HI: r = c & !z;
            COND_LS: r = !c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = !z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ---- stage p0: decode condition, interlock, evaluate -------------------
    always_comb begin
        sel_in_range = sel_ok(in_flag_sel);
        wb_in_range  = wb_valid & sel_ok(wb_flag_sel);
        wb_hit       = wb_in_range & (wb_flag_sel == in_flag_sel);
        pend_cur     = pend_q[in_flag_sel];
        cond_p0      = e_cond'(in_instruction[COND_LSB +: 4]);
        dep_p0       = (cond_p0 != COND_AL) && (cond_p0 != COND_NV);
`ifdef COND_UNIT_WB_BYPASS_EN
        // The writeback retiring the last outstanding writer supplies the
        // flags this instruction must see, so forward it.
        set_ready  = (pend_cur == '0) | (wb_hit & (pend_cur == PEND_ONE));
        eval_flags = (wb_hit & (pend_cur == PEND_ONE)) ? wb_flags
                                                       : flags_q[in_flag_sel];
`else
        set_ready  = (pend_cur == '0);
        eval_flags = flags_q[in_flag_sel];
`endif
        pass_p0 = cond_eval(cond_p0, eval_flags);
        // A saturated counter can still take a new writer when one retires
        // in the same cycle: the count then stays put.
        stall = (dep_p0 & !set_ready) |
                (in_sets_flags & (pend_cur == PEND_MAX) & !wb_hit);
        in_ready = !stall & (!out_valid | out_ready) & rst_n & !flush;
        accept   = in_valid & in_ready;
        for (int s = 0; s < NSETS; s++) begin
            pend_inc[s]   = accept & in_sets_flags & sel_in_range &
                            (in_flag_sel == FSEL_W'(s));
            wb_sel_vec[s] = wb_in_range & (wb_flag_sel == FSEL_W'(s));
        end
    end

    // ---- flag and pending-counter state ------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSETS; s++) begin
                flags_q[s] <= 4'b0000;
            end
        end else begin
            // Flush deliberately leaves architectural flags alone.
            for (int s = 0; s < NSETS; s++) begin
                if (wb_sel_vec[s]) begin
                    flags_q[s] <= wb_flags;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSETS; s++) begin
                pend_q[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < NSETS; s++) begin
                pend_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSETS; s++) begin
                if (pend_inc[s] & !wb_sel_vec[s]) begin
                    pend_q[s] <= pend_q[s] + PEND_ONE;
                end else if (wb_sel_vec[s] & !pend_inc[s] & (pend_q[s] != '0)) begin
                    // A stray writeback at zero still updates flags above.
                    pend_q[s] <= pend_q[s] - PEND_ONE;
                end
            end
        end
    end

    // ---- stage p1: registered output to issue ------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_kind       <= KIND_ALU;
            out_cond       <= COND_NV;
            out_pass       <= 1'b0;
            out_sets_flags <= 1'b0;
            out_flag_sel   <= '0;
        end else if (accept) begin
            out_kind       <= in_kind;
            out_cond       <= cond_p0;
            out_pass       <= pass_p0;
            out_sets_flags <= in_sets_flags;
            out_flag_sel   <= in_flag_sel;
        end
    end

endmodule
